// File: rtl/multu_hilo_pkg.sv
// Shared definitions for the multiplier and the downstream ALU result mux:
// R-type funct codes and the multiplier FSM state encoding.
package multu_hilo_pkg;

  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier owning the Hi/Lo register pair.
// One product bit is retired per cycle; Hi/Lo are committed together at the end.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] MULTU_FUNCT = FUNCT_MULTU
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [0:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_accept;
  logic               w_last;

  // Carry out of the partial-product add re-enters at the MSB on the shift.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  assign w_accept   = start && (Signal == MULTU_FUNCT);
  assign w_last     = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mcand <= src_a;
            r_prod  <= {{WIDTH{1'b0}}, src_b};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_prod  <= w_prod_nxt;
          r_count <= r_count + CW'(1);
          // Hi/Lo keep the previous product until the final iteration lands.
          if (w_last) begin
            r_hi    <= w_prod_nxt[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_nxt[WIDTH-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign HiOut = r_hi;
  assign LoOut = r_lo;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
